// File: rtl/optical_flow_stream_ctrl.sv
// -----------------------------------------------------------------------------
// optical_flow_stream_ctrl
//   Multi-frame sequencer and output stage that sits after the flow solver.
//   Each solver result accepted while running is tagged with its raster
//   position (x,y). It is also flagged when it lies in the window-border band,
//   optionally zeroed there, and queued in an output FIFO with valid/ready
//   handshaking. A run covers frame_count frames (0 = run until abort). A run
//   can be aborted at any time, and a sticky flag records FIFO overflow drops.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, abort        run control pulses (abort wins over start)
//   frame_count[7:0]    frames per run, sampled on start; 0 = continuous
//   busy, done          status: running/draining, 1-cycle run-complete pulse
//   error_ovf           sticky: a result was dropped on a full FIFO
//   frames_done[7:0]    frames completed in this run (wraps)
//   in_valid, in_u/v    solver results (no backpressure toward the solver)
//   out_valid/ready     output handshake; out_valid = FIFO non-empty
//   out_x/y/u/v         queued result and its raster position
//   out_border/last     border-band flag, last pixel of a frame
// -----------------------------------------------------------------------------
module optical_flow_stream_ctrl #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int FLOW_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int BORDER       = 2,
    parameter int ZERO_BORDER  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [7:0]                   frame_count,
    output logic                         busy,
    output logic                         done,
    output logic                         error_ovf,
    output logic [7:0]                   frames_done,
    input  logic                         in_valid,
    input  logic signed [FLOW_WIDTH-1:0] in_u,
    input  logic signed [FLOW_WIDTH-1:0] in_v,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [9:0]                   out_x,
    output logic [8:0]                   out_y,
    output logic signed [FLOW_WIDTH-1:0] out_u,
    output logic signed [FLOW_WIDTH-1:0] out_v,
    output logic                         out_border,
    output logic                         out_last
);

    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [9:0] X_LAST  = 10'(IMAGE_WIDTH - 1);
    localparam logic [8:0] Y_LAST  = 9'(IMAGE_HEIGHT - 1);
    localparam logic [9:0] X_LO    = 10'(BORDER);
    localparam logic [9:0] X_HI    = 10'(IMAGE_WIDTH - BORDER);
    localparam logic [8:0] Y_LO    = 9'(BORDER);
    localparam logic [8:0] Y_HI    = 9'(IMAGE_HEIGHT - BORDER);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [9:0]                   x;
        logic [8:0]                   y;
        logic signed [FLOW_WIDTH-1:0] u;
        logic signed [FLOW_WIDTH-1:0] v;
        logic                         border;
        logic                         last;
    } entry_t;

    function automatic logic in_border(input logic [9:0] x, input logic [8:0] y);
        return (x < X_LO) || (x >= X_HI) || (y < Y_LO) || (y >= Y_HI);
    endfunction

    function automatic logic signed [FLOW_WIDTH-1:0] mask_flow(
        input logic signed [FLOW_WIDTH-1:0] f,
        input logic                         border
    );
        return ((ZERO_BORDER != 0) && border) ? '0 : f;
    endfunction

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [7:0]  frames_done_q, frames_done_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic        error_ovf_q, error_ovf_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    entry_t mem [FIFO_DEPTH];
    entry_t entry_in;
    entry_t head;

    logic pop, push, full, accept, at_eol, at_last, cur_border;

    always_comb begin
        pop        = (count_q != '0) && out_ready;
        full       = (count_q == DEPTH_C);
        // abort wins: a result arriving on the abort cycle is discarded
        accept     = (state_q == S_RUN) && in_valid && !abort;
        // a pop on the same edge frees a slot, so a full FIFO still accepts
        push       = accept && (!full || pop);
        at_eol     = (x_q == X_LAST);
        at_last    = at_eol && (y_q == Y_LAST);
        cur_border = in_border(x_q, y_q);

        entry_in.x      = x_q;
        entry_in.y      = y_q;
        entry_in.u      = mask_flow(in_u, cur_border);
        entry_in.v      = mask_flow(in_v, cur_border);
        entry_in.border = cur_border;
        entry_in.last   = at_last;
    end

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        frames_done_d = frames_done_q;
        frame_count_d = frame_count_q;
        error_ovf_d   = error_ovf_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Coordinates advance for every accepted result, dropped or not, so
        // the raster stays aligned with the solver's stream.
        if (accept) begin
            if (full && !pop) error_ovf_d = 1'b1;
            if (at_eol) begin
                x_d = '0;
                y_d = at_last ? 9'd0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
            if (at_last) begin
                frames_done_d = frames_done_q + 8'd1;
                if ((frame_count_q != 8'd0) && (frames_done_q + 8'd1 == frame_count_q))
                    state_d = S_DRAIN;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d       = S_RUN;
                    frame_count_d = frame_count;
                    frames_done_d = '0;
                    error_ovf_d   = 1'b0;
                    x_d           = '0;
                    y_d           = '0;
                end
            end
            S_DRAIN: if (count_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase

        if (abort) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            frames_done_q <= '0;
            frame_count_q <= '0;
            error_ovf_q   <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frames_done_q <= frames_done_d;
            frame_count_q <= frame_count_d;
            error_ovf_q   <= error_ovf_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // FIFO storage holds data only; validity comes from count_q.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= entry_in;
    end

    always_comb begin
        head        = mem[rd_ptr_q];
        out_valid   = (count_q != '0);
        out_x       = out_valid ? head.x      : '0;
        out_y       = out_valid ? head.y      : '0;
        out_u       = out_valid ? head.u      : '0;
        out_v       = out_valid ? head.v      : '0;
        out_border  = out_valid ? head.border : 1'b0;
        out_last    = out_valid ? head.last   : 1'b0;
        busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
        done        = (state_q == S_DONE);
        error_ovf   = error_ovf_q;
        frames_done = frames_done_q;
    end

endmodule
